bus_master_ctrl: RTL and testbench
==================================

Name: bus_master_ctrl

Overview:
- Initiator end of the on-chip valid/ready register bus. It drives the `bus_if.master` modport and issues one read or write at a time.
- Commands come from a local request port. The block waits for the responder's `ready`, captures `read_data`, and returns a response through a held handshake.
- A bounded wait guards against a responder that never answers; on timeout the block reports an error instead of hanging.
- Sits between CPU/test-sequencer logic and any bus responder, for example the register slave.

Parameters:
- ADDR_W, 32, address width driven on busc.addr.
- DATA_W, 32, write/read data width; must equal the bus_if data width.
- TIMEOUT_CYCLES, 16, maximum number of cycles valid is held without ready before an error response; legal range 2..1024.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  local command present.
- req_ready  output  1  block can accept a command; high only in ST_IDLE.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  command address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- resp_valid  output  1  response held until accepted.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  DATA_W  captured read data; 0 for writes and for errors.
- resp_err  output  1  1 = timeout, no ready seen.
- busc  interface  bus_if.master  drives valid, read, write, addr, write_data; samples ready and read_data.

Behaviour:
- Reset values (async, immediate): state=ST_IDLE; busc.valid/read/write=0; busc.addr/write_data=0; resp_valid=0; resp_err=0; resp_rdata=0; timeout count=0. req_ready follows state==ST_IDLE, so it is 1 during and after reset.
- Outputs: all bus outputs and resp_* are registered. req_ready is the only combinational output.
- ST_IDLE:
  - req_valid && req_ready is the accept cycle (call it T0).
  - On accept, latch addr, wdata and write; clear the count; go to ST_REQ.
  - busc.valid rises at T0+1, with read = !write and write = write.
- ST_REQ:
  - valid, read, write, addr and write_data are held stable every cycle.
  - Sampled ready=1: capture read_data into resp_rdata if read (0 if write); resp_err=0; drop valid/read/write next cycle; go to ST_RESP.
  - Otherwise: increment the count. When count == TIMEOUT_CYCLES-1 and ready is still 0: resp_err=1, resp_rdata=0, drop valid, go to ST_RESP.
  - If ready arrives in the same cycle the count hits its limit, ready wins (no error).
  - The counter saturates and never wraps.
- ST_RESP:
  - resp_valid=1, with resp_rdata and resp_err held.
  - When resp_ready=1: resp_valid drops next cycle; go to ST_GAP.
  - Back-pressure may be unbounded.
- ST_GAP:
  - One cycle with valid=0 and req_ready=0, then ST_IDLE.
  - Guarantees at least one idle cycle on the bus between transactions so the responder returns to its idle state.
- Latency against a responder whose ready appears 2 cycles after valid is first seen:
  - valid high T0+1..T0+3.
  - ready sampled at T0+3.
  - resp_valid at T0+4.
  - With resp_ready tied to 1, the next command is accepted at T0+6.
- req_valid outside ST_IDLE is ignored; the command stays pending on the requester side.
- Reset asserted mid-transaction: valid drops asynchronously, the response is lost and no resp_valid is issued. After deassertion the block is in ST_IDLE.
- read_data is sampled only in the cycle where ready=1; read_data is never sampled otherwise.

Decomposition:
- bus_pkg holds:
  - the state enum (ST_IDLE, ST_REQ, ST_RESP, ST_GAP, 2 bits);
  - default width constants (BUS_ADDR_W=32, BUS_DATA_W=32);
  - a resp_t struct {rdata, err}.
- One sub-module, bus_timeout_cnt: a parameterised saturating counter with inputs clear and enable, output expired. Its width is $clog2(TIMEOUT_CYCLES)+1.
- The FSM and datapath latches stay in bus_master_ctrl.

Test Plan:
- Single read: req_addr=32'h10, responder ready 2 cycles after valid, read_data=32'hCAFEBABE -> valid high 3 cycles, resp_valid at T0+4, resp_rdata=32'hCAFEBABE, resp_err=0.
- Single write: req_wdata=32'h1234_5678, addr=32'h20 -> busc.write=1, read=0, write_data stable for the whole valid window; response rdata=0, err=0.
- Timeout: responder never asserts ready, TIMEOUT_CYCLES=16 -> valid high exactly 16 cycles, then resp_err=1, resp_rdata=0, the bus returns idle, and the next command is accepted.
- Ready on the last allowed cycle (cycle 16) -> normal response with err=0. Ready on cycle 17 is never observed.
- Back-pressure: resp_ready held low for 10 cycles -> resp_valid, resp_rdata and resp_err are stable; req_ready=0 throughout; one ST_GAP cycle after acceptance.
- Reset pulse while in ST_REQ -> valid=0 immediately, no resp_valid. Post-reset read of 32'h10 completes normally with 32'hCAFEBABE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the valid/ready register bus initiator.
// Contents:
//   state_t    - initiator FSM states (2-bit encoding)
//   BUS_ADDR_W - default address width
//   BUS_DATA_W - default data width
//   resp_t     - response payload returned to the local requester
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] rdata;
    logic                  err;
  } resp_t;

endpackage

// File: rtl/bus_if.sv
// On-chip valid/ready register bus.
// Signals:
//   valid      - initiator has a transfer on the bus
//   read/write - transfer direction (exactly one set while valid)
//   addr       - transfer address
//   write_data - data for writes
//   ready      - responder completes the transfer this cycle
//   read_data  - responder data, meaningful only while ready=1
// Modports: master (initiator side), slave (responder side).
interface bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              valid;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              ready;
  logic [DATA_W-1:0] read_data;

  modport master (
    output valid, read, write, addr, write_data,
    input  ready, read_data
  );

  modport slave (
    input  valid, read, write, addr, write_data,
    output ready, read_data
  );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Saturating wait counter that bounds how long the initiator holds valid.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   clear   - restart the count at zero (start of a transfer)
//   enable  - count one more cycle without ready
//   expired - the count has reached TIMEOUT_CYCLES-1, i.e. this is the
//             last cycle the transfer may wait
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Stops at LIMIT so a long stall can never wrap back to a small count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/bus_master_ctrl.sv
// Initiator end of the valid/ready register bus. Accepts one local command
// at a time, drives it onto the bus until the responder answers or the wait
// bound runs out, then holds a response until the requester takes it.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   req_valid/req_ready    - local command handshake (req_ready only in idle)
//   req_write/addr/wdata   - command contents
//   resp_valid/resp_ready  - held response handshake
//   resp_rdata/resp_err    - read data (0 for writes/errors), timeout flag
//   busc                   - bus_if master modport
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  bus_if.master             busc
);

  state_t            r_state, w_state_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_read, w_read_nxt;
  logic              r_write, w_write_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  resp_t             r_resp, w_resp_nxt;

  logic w_clear;
  logic w_enable;
  logic w_expired;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .enable (w_enable),
    .expired(w_expired)
  );

  // State and every outgoing bus/response signal are registered here, so
  // reset pulls valid low immediately and the response is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_valid      <= w_valid_nxt;
      r_read       <= w_read_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp       <= w_resp_nxt;
    end
  end

  // Next-state and next-register logic. Everything holds by default; the
  // command is latched once on accept so later changes on the request port
  // cannot disturb the transfer in flight. A ready in the final allowed
  // cycle is checked before the timeout, so it completes normally.
  always_comb begin
    w_state_nxt      = r_state;
    w_valid_nxt      = r_valid;
    w_read_nxt       = r_read;
    w_write_nxt      = r_write;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_nxt       = r_resp;
    w_clear          = 1'b0;
    w_enable         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_REQ;
          w_valid_nxt = 1'b1;
          w_read_nxt  = !req_write;
          w_write_nxt = req_write;
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          w_clear     = 1'b1;
        end
      end

      ST_REQ: begin
        if (busc.ready) begin
          w_resp_nxt.rdata = r_read ? busc.read_data : '0;
          w_resp_nxt.err   = 1'b0;
          w_valid_nxt      = 1'b0;
          w_read_nxt       = 1'b0;
          w_write_nxt      = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = ST_RESP;
        end else if (w_expired) begin
          w_resp_nxt.rdata = '0;
          w_resp_nxt.err   = 1'b1;
          w_valid_nxt      = 1'b0;
          w_read_nxt       = 1'b0;
          w_write_nxt      = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = ST_RESP;
        end else begin
          w_enable = 1'b1;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = ST_GAP;
        end
      end

      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready       = (r_state == ST_IDLE);
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp.rdata;
  assign resp_err        = r_resp.err;
  assign busc.valid      = r_valid;
  assign busc.read       = r_read;
  assign busc.write      = r_write;
  assign busc.addr       = r_addr;
  assign busc.write_data = r_wdata;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench for bus_master_ctrl. The bench plays both the local
// requester and the bus responder, and predicts each transaction from the
// timing rules: a ready on valid-cycle k (1..TIMEOUT) completes after k
// valid cycles, anything else times out after TIMEOUT valid cycles.
module tb_bus_master_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int testCount = 0;
  int failCount = 0;

  bus_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

  bus_master_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busc      (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a command on the request port (called at a falling edge).
  task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
  endtask

  // One full transaction: readyCycle is the valid cycle (1-based) on which
  // the responder raises ready (0 = never); holdCycles is how long the
  // response is back-pressured.
  task automatic runTransaction(input string name, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int readyCycle,
                                input int holdCycles);
    int          vc;
    bit          done;
    bit          busOk;
    bit          respOk;
    bit          expErr;
    int          expVc;
    logic [31:0] expRdata;

    expErr   = !(readyCycle >= 1 && readyCycle <= TIMEOUT);
    expVc    = expErr ? TIMEOUT : readyCycle;
    expRdata = (wr || expErr) ? 32'h0 : rdata;

    applyStimulus(wr, addr, wdata);
    checkOutput({name, ".reqReadyIdle"}, 64'(req_ready), 64'd1);

    vc    = 0;
    done  = 1'b0;
    busOk = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      // A different command stays pending; it must not disturb the transfer.
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_write = ~wr;
      if (busIf.valid) begin
        vc++;
        if (busIf.addr !== addr || busIf.write !== wr || busIf.read !== !wr ||
            (wr && busIf.write_data !== wdata) || req_ready !== 1'b0)
          busOk = 1'b0;
        busIf.ready     = (vc == readyCycle);
        busIf.read_data = (vc == readyCycle) ? rdata : $urandom;
      end else begin
        busIf.ready     = 1'b0;
        busIf.read_data = $urandom;
        req_valid       = 1'b0;
        done            = 1'b1;
      end
    end

    checkOutput({name, ".validCycles"}, 64'(vc), 64'(expVc));
    checkOutput({name, ".busStable"}, 64'(busOk), 64'd1);
    checkOutput({name, ".respValid"}, 64'(resp_valid), 64'd1);
    checkOutput({name, ".respRdata"}, 64'(resp_rdata), 64'(expRdata));
    checkOutput({name, ".respErr"}, 64'(resp_err), 64'(expErr));
    checkOutput({name, ".busDirIdle"}, 64'({busIf.read, busIf.write}), 64'd0);

    respOk     = 1'b1;
    resp_ready = (holdCycles == 0);
    for (int h = 1; h <= holdCycles; h++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== expRdata ||
          resp_err !== expErr || req_ready !== 1'b0 || busIf.valid !== 1'b0)
        respOk = 1'b0;
      if (h == holdCycles) resp_ready = 1'b1;
    end
    if (holdCycles > 0)
      checkOutput({name, ".respHeld"}, 64'(respOk), 64'd1);

    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({name, ".gapRespValid"}, 64'(resp_valid), 64'd0);
    checkOutput({name, ".gapReqReady"}, 64'(req_ready), 64'd0);
    checkOutput({name, ".gapBusValid"}, 64'(busIf.valid), 64'd0);

    @(negedge clk);
    checkOutput({name, ".idleReqReady"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    bit quietOk;

    reset           = 1'b0;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    resp_ready      = 1'b0;
    busIf.ready     = 1'b0;
    busIf.read_data = '0;

    // Values while reset is held.
    #12;
    checkOutput("rst.busValid", 64'(busIf.valid), 64'd0);
    checkOutput("rst.busDir", 64'({busIf.read, busIf.write}), 64'd0);
    checkOutput("rst.busAddr", 64'(busIf.addr), 64'd0);
    checkOutput("rst.busWdata", 64'(busIf.write_data), 64'd0);
    checkOutput("rst.respValid", 64'(resp_valid), 64'd0);
    checkOutput("rst.respErr", 64'(resp_err), 64'd0);
    checkOutput("rst.respRdata", 64'(resp_rdata), 64'd0);
    checkOutput("rst.reqReady", 64'(req_ready), 64'd1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    runTransaction("read", 1'b0, 32'h10, 32'h0, 32'hCAFEBABE, 3, 0);
    runTransaction("write", 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_0001, 3, 0);
    runTransaction("timeout", 1'b0, 32'h30, 32'h0, 32'h5555_AAAA, 0, 0);
    runTransaction("lastCycle", 1'b0, 32'h40, 32'h0, 32'h0BAD_F00D, TIMEOUT, 0);
    runTransaction("lateReady", 1'b0, 32'h44, 32'h0, 32'h1111_2222, TIMEOUT + 1, 0);
    runTransaction("backPressure", 1'b0, 32'h50, 32'h0, 32'h7654_3210, 1, 10);
    runTransaction("wrTimeout", 1'b1, 32'h54, 32'hA5A5_5A5A, 32'h9999_8888, 0, 2);

    // Reset while the transfer is waiting for ready.
    applyStimulus(1'b0, 32'h10, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      req_valid   = 1'b0;
      busIf.ready = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midRst.busValid", 64'(busIf.valid), 64'd0);
    checkOutput("midRst.respValid", 64'(resp_valid), 64'd0);
    checkOutput("midRst.reqReady", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset   = 1'b1;
    quietOk = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busIf.valid !== 1'b0 || req_ready !== 1'b1)
        quietOk = 1'b0;
    end
    checkOutput("midRst.quiet", 64'(quietOk), 64'd1);
    runTransaction("postRst", 1'b0, 32'h10, 32'h0, 32'hCAFEBABE, 3, 0);

    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      runTransaction("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
                     $urandom, int'($urandom_range(0, TIMEOUT + 2)),
                     int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
